irq_tick_aggregator: RTL and testbench
======================================

Name: irq_tick_aggregator

Overview:
- Downstream consumer of the interval-timer `irq` line and of other peripheral interrupt levels.
- Edge-detects up to NUM_SRC level interrupt inputs and latches one pending bit per source.
- Counts ticks that arrive while a source is already pending ("missed" events), so the CPU can re-deliver them.
- Presents a masked, priority-encoded single `irq` to the CPU through a 16-bit Avalon-MM slave with the same register-access style as the timer.

Parameters:
- NUM_SRC, 4, number of interrupt sources (1..16).
- CNT_W, 4, width of the per-source saturating missed-event counter (1..8).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- address  input  3  register word address.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe; write occurs when chipselect && ~write_n.
- writedata  input  16  write data.
- irq_in  input  NUM_SRC  level interrupt inputs (same clock domain, e.g. timer irq on bit 0).
- readdata  output  16  registered read data.
- irq  output  1  aggregated interrupt to CPU, registered.

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high. When reset is sampled high, all state clears:
  - prev_in, pending, mask, sel, readdata and irq are all 0.
  - All missed counters are 0.
- Edge detect: `prev_in <= irq_in` every cycle, and `edge = irq_in & ~prev_in`. An input already high at reset release therefore registers exactly one event on the first cycle after reset.
- Per-source update, evaluated in priority order:
  - (a) W1C (addr 0, writedata[i]=1) and edge[i] in the same cycle: pending=1, missed=0.
  - (b) W1C only: pending=0, missed=0.
  - (c) ACK of source i (addr 3, writedata[3:0]=i) and edge[i] in the same cycle: pending and missed unchanged.
  - (d) ACK only: if missed>0, missed decrements and pending stays 1. Otherwise pending=0.
  - (e) edge only: if pending=0, set pending=1. Otherwise missed increments, saturating at 2^CNT_W-1.
- Write side effects:
  - ACK with id >= NUM_SRC is ignored.
  - ACK of a non-pending source is a no-op.
  - W1C bits >= NUM_SRC are ignored.
- Active source: `act_id` is the lowest index i with pending[i] & mask[i]; `act_valid` is high when any such source exists.
- irq: `irq <= act_valid` (registered).
  - If irq_in is sampled high at edge k, pending is visible after edge k and irq rises after edge k+1.
  - Clearing the last masked pending source drops irq one cycle after the clearing write.
- Register map (16-bit; unimplemented bits read 0):
  - 0 PENDING: R gives pending[NUM_SRC-1:0]; W is W1C.
  - 1 MASK: RW, [NUM_SRC-1:0].
  - 2 ACTIVE: R gives {act_valid at bit 15, zeros, act_id at [3:0]}; act_id reads 0 when not valid; writes ignored.
  - 3 ACK: W only, id in [3:0]; reads 0.
  - 4 MISSED: R gives the missed counter of source `sel`, zero-extended; 0 if sel >= NUM_SRC; writes ignored.
  - 5 SEL: RW, [3:0].
  - 6 RAW: R gives prev_in (the registered inputs); writes ignored.
  - 7: reads 0, writes ignored.
- Reads: `readdata <= read_mux(address)` every cycle, independent of chipselect, so there is 1-cycle read latency.
  - A read of the same cycle as a write returns the pre-write value.
- Mask affects only irq and ACTIVE; pending and missed accumulate while masked.
- Reset mid-operation clears all pending and missed state. Events in flight on that cycle are lost.

Test Plan:
- Reset, then irq_in=0 → readdata=0 at all addresses, irq=0. Hold irq_in[0]=1 through reset release → PENDING=0x0001 one cycle later.
- MASK=0xF; pulse irq_in[2] high for 3 cycles → exactly one event: PENDING=0x0004, ACTIVE=0x8002, irq high 2 edges after first high sample.
- Three more rising edges on src 0 while pending (CNT_W=4) → MISSED (SEL=0) = 3. Four ACK id 0 writes → missed 2,1,0, then pending[0] clears and irq drops next cycle.
- 20 edges on src 1 while pending → MISSED saturates at 15. W1C 0x0002 → PENDING bit 1=0, MISSED=0.
- Same-cycle ACK id 3 and rising edge on src 3 with missed=1 → missed stays 1, pending stays 1. Same-cycle W1C 0x0008 and edge → pending=1, missed=0.
- Sources 1 and 3 pending, MASK=0x8 → ACTIVE=0x8003. MASK=0xA → ACTIVE=0x8001. MASK=0 → ACTIVE=0x0000, irq=0. ACK id 9 → no state change.

Source files
------------

// File: rtl/irq_tick_aggregator.sv
// -----------------------------------------------------------------------------
// irq_tick_aggregator
//
// Collects up to NUM_SRC level interrupt lines, such as the interval timer irq
// on bit 0. It turns each rising edge into a latched pending bit. Edges that
// arrive while a source is already pending are counted in a per-source
// saturating "missed" counter, so the CPU can re-deliver those ticks.
//
// A masked, lowest-index-first priority encoder drives a single registered irq
// to the CPU. Software reaches the block through a small 16-bit Avalon-MM slave
// that has one cycle of read latency.
//
// Ports
//   clk         system clock, all state on the rising edge
//   reset       synchronous, active-high reset
//   address     register word address (0..7)
//   chipselect  slave select
//   write_n     active-low write strobe (write = chipselect && !write_n)
//   writedata   write data
//   irq_in      level interrupt inputs, already in the clk domain
//   readdata    registered read data for the address of the previous cycle
//   irq         registered aggregated interrupt request
//
// Register map (unimplemented bits read 0)
//   0 PENDING  R: pending bits          W: write-1-to-clear
//   1 MASK     RW [NUM_SRC-1:0]
//   2 ACTIVE   R: {act_valid, 11'b0, act_id[3:0]}
//   3 ACK      W: source id in [3:0]    reads 0
//   4 MISSED   R: missed counter of source SEL (0 if SEL >= NUM_SRC)
//   5 SEL      RW [3:0]
//   6 RAW      R: registered inputs (prev_in)
//   7          reads 0
// -----------------------------------------------------------------------------
module irq_tick_aggregator #(
   parameter int NUM_SRC = 4,   // 1..16
   parameter int CNT_W   = 4    // 1..8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [2:0]         address,
   input  logic               chipselect,
   input  logic               write_n,
   input  logic [15:0]        writedata,
   input  logic [NUM_SRC-1:0] irq_in,
   output logic [15:0]        readdata,
   output logic               irq
);

   typedef enum logic [2:0] {
      REG_PENDING = 3'd0,
      REG_MASK    = 3'd1,
      REG_ACTIVE  = 3'd2,
      REG_ACK     = 3'd3,
      REG_MISSED  = 3'd4,
      REG_SEL     = 3'd5,
      REG_RAW     = 3'd6,
      REG_NONE    = 3'd7
   } reg_addr_e;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [NUM_SRC-1:0] prev_in;
   logic [NUM_SRC-1:0] pending;
   logic [NUM_SRC-1:0] mask;
   logic [3:0]         sel;
   logic [CNT_W-1:0]   missed [NUM_SRC];

   // ---------------------------------------------------------------------------
   // Write decode
   // ---------------------------------------------------------------------------
   logic               wr_en;
   logic [NUM_SRC-1:0] w1c_hit;
   logic [NUM_SRC-1:0] ack_hit;
   logic [NUM_SRC-1:0] rise;

   assign wr_en = chipselect & ~write_n;
   assign rise  = irq_in & ~prev_in;

   // The ACK id is compared against each in-range index. An id >= NUM_SRC
   // therefore matches no source and the write is silently dropped.
   always_comb begin
      // NOTE: every output of a combinational block gets a default before any
      // conditional assignment, so that no path leaves it unassigned and
      // infers a latch.
      w1c_hit = '0;
      ack_hit = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         w1c_hit[i] = wr_en && (address == REG_PENDING) && writedata[i];
         ack_hit[i] = wr_en && (address == REG_ACK) && (writedata[3:0] == 4'(i));
      end
   end

   // ---------------------------------------------------------------------------
   // Per-source pending / missed next state, in priority order:
   //   W1C beats everything. If an edge arrives in the same cycle as a W1C,
   //   that edge starts a fresh event.
   //   An ACK together with an edge cancels out: one event is retired and one
   //   arrives.
   //   An ACK alone retires a missed tick first and drops pending only when
   //   none remain.
   //   An edge alone either raises pending or counts a missed tick.
   // ---------------------------------------------------------------------------
   logic [NUM_SRC-1:0] pending_nxt;
   logic [CNT_W-1:0]   missed_nxt [NUM_SRC];

   always_comb begin
      pending_nxt = pending;
      for (int i = 0; i < NUM_SRC; i++) begin
         missed_nxt[i] = missed[i];
         if (w1c_hit[i]) begin
            pending_nxt[i] = rise[i];
            missed_nxt[i]  = '0;
         end else if (ack_hit[i]) begin
            if (!rise[i] && pending[i]) begin
               if (missed[i] != '0) begin
                  missed_nxt[i] = missed[i] - 1'b1;
               end else begin
                  pending_nxt[i] = 1'b0;
               end
            end
         end else if (rise[i]) begin
            if (!pending[i]) begin
               pending_nxt[i] = 1'b1;
            end else if (missed[i] != CNT_MAX) begin
               missed_nxt[i] = missed[i] + 1'b1;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Priority encoder: the lowest-index masked pending source wins. Scanning
   // from the top down lets the lowest index overwrite the higher ones.
   // ---------------------------------------------------------------------------
   logic [NUM_SRC-1:0] active_vec;
   logic               act_valid;
   logic [3:0]         act_id;

   assign active_vec = pending & mask;
   assign act_valid  = |active_vec;

   always_comb begin
      act_id = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (active_vec[i]) begin
            act_id = 4'(i);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Read mux
   // ---------------------------------------------------------------------------
   logic [CNT_W-1:0] missed_sel;
   logic [15:0]      read_mux;

   always_comb begin
      missed_sel = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (sel == 4'(i)) begin
            missed_sel = missed[i];
         end
      end
   end

   always_comb begin
      read_mux = '0;
      case (address)
         REG_PENDING: read_mux[NUM_SRC-1:0] = pending;
         REG_MASK:    read_mux[NUM_SRC-1:0] = mask;
         REG_ACTIVE:  begin
            read_mux[15]  = act_valid;
            read_mux[3:0] = act_id;
         end
         REG_MISSED:  read_mux[CNT_W-1:0]   = missed_sel;
         REG_SEL:     read_mux[3:0]         = sel;
         REG_RAW:     read_mux[NUM_SRC-1:0] = prev_in;
         default:     read_mux = '0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments, so every register
      // samples the pre-edge values. This is also why a read in the same cycle
      // as a write returns the old contents.
      if (reset) begin
         prev_in  <= '0;
         pending  <= '0;
         mask     <= '0;
         sel      <= '0;
         readdata <= '0;
         irq      <= 1'b0;
         // NOTE: the missed counters are architectural state that software
         // reads after reset, so they are reset explicitly rather than treated
         // as uninitialised storage.
         for (int i = 0; i < NUM_SRC; i++) begin
            missed[i] <= '0;
         end
      end else begin
         prev_in  <= irq_in;
         pending  <= pending_nxt;
         for (int i = 0; i < NUM_SRC; i++) begin
            missed[i] <= missed_nxt[i];
         end
         if (wr_en && (address == REG_MASK)) begin
            mask <= writedata[NUM_SRC-1:0];
         end
         if (wr_en && (address == REG_SEL)) begin
            sel <= writedata[3:0];
         end
         readdata <= read_mux;
         irq      <= act_valid;
      end
   end

endmodule

// File: tb/tb_irq_tick_aggregator.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for irq_tick_aggregator (NUM_SRC=4, CNT_W=4).
// Inputs change on the falling edge and outputs are sampled on the falling
// edge, half a period away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_irq_tick_aggregator;

   localparam int NUM_SRC = 4;
   localparam int CNT_W   = 4;

   logic               clk = 1'b0;
   logic               reset;
   logic [2:0]         address;
   logic               chipselect;
   logic               write_n;
   logic [15:0]        writedata;
   logic [NUM_SRC-1:0] irq_in;
   logic [15:0]        readdata;
   logic               irq;

   int tests_run    = 0;
   int tests_failed = 0;

   irq_tick_aggregator #(
      .NUM_SRC (NUM_SRC),
      .CNT_W   (CNT_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .irq_in     (irq_in),
      .readdata   (readdata),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
   endtask

   task automatic rd(input string tag, input logic [2:0] a, input logic [15:0] exp);
      address = a;
      tick();
      check(tag, readdata, exp);
   endtask

   task automatic pulse(input int s);
      irq_in[s] = 1'b1;
      tick();
      irq_in[s] = 1'b0;
      tick();
   endtask

   initial begin
      reset      = 1'b1;
      address    = '0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      irq_in     = '0;
      tick();
      tick();
      reset = 1'b0;

      // Reset state: every address reads 0, irq low.
      for (int a = 0; a < 8; a++) begin
         rd($sformatf("reset_rd%0d", a), 3'(a), 16'h0000);
      end
      check("reset_irq", {15'b0, irq}, 16'h0000);

      // Input held high through reset release gives one event.
      reset     = 1'b1;
      irq_in[0] = 1'b1;
      tick();
      tick();
      reset   = 1'b0;
      address = 3'd0;
      tick();
      rd("pend_after_rst", 3'd0, 16'h0001);
      check("irq_unmasked", {15'b0, irq}, 16'h0000);
      irq_in[0] = 1'b0;
      tick();

      // Clear it, unmask everything, then a 3-cycle pulse on src 2.
      wr(3'd0, 16'h0001);
      rd("w1c_src0", 3'd0, 16'h0000);
      wr(3'd1, 16'h000F);
      check("irq_idle", {15'b0, irq}, 16'h0000);
      irq_in[2] = 1'b1;
      tick();
      check("irq_k", {15'b0, irq}, 16'h0000);
      tick();
      check("irq_k1", {15'b0, irq}, 16'h0001);
      tick();
      irq_in[2] = 1'b0;
      rd("pend_src2", 3'd0, 16'h0004);
      rd("active_src2", 3'd2, 16'h8002);
      wr(3'd5, 16'h0002);
      rd("missed_src2", 3'd4, 16'h0000);

      // Src 0: one event plus three missed, then drain with ACKs.
      wr(3'd0, 16'h0004);
      repeat (4) pulse(0);
      wr(3'd5, 16'h0000);
      rd("missed0_3", 3'd4, 16'h0003);
      rd("pend0", 3'd0, 16'h0001);
      wr(3'd3, 16'h0000);
      rd("missed0_2", 3'd4, 16'h0002);
      wr(3'd3, 16'h0000);
      rd("missed0_1", 3'd4, 16'h0001);
      wr(3'd3, 16'h0000);
      rd("missed0_0", 3'd4, 16'h0000);
      rd("pend0_kept", 3'd0, 16'h0001);
      check("irq_src0", {15'b0, irq}, 16'h0001);
      wr(3'd3, 16'h0000);
      check("irq_hold", {15'b0, irq}, 16'h0001);
      tick();
      check("irq_drop", {15'b0, irq}, 16'h0000);
      rd("pend0_clr", 3'd0, 16'h0000);

      // Src 1: 20 edges saturate missed at 15, W1C clears both.
      repeat (20) pulse(1);
      wr(3'd5, 16'h0001);
      rd("missed1_sat", 3'd4, 16'h000F);
      rd("pend1", 3'd0, 16'h0002);
      wr(3'd0, 16'h0002);
      rd("pend1_w1c", 3'd0, 16'h0000);
      rd("missed1_w1c", 3'd4, 16'h0000);

      // Src 3: ACK plus edge in the same cycle, then W1C plus edge.
      pulse(3);
      pulse(3);
      wr(3'd5, 16'h0003);
      rd("missed3_1", 3'd4, 16'h0001);
      irq_in[3] = 1'b1;
      wr(3'd3, 16'h0003);
      irq_in[3] = 1'b0;
      tick();
      rd("ack_edge_missed", 3'd4, 16'h0001);
      rd("ack_edge_pend", 3'd0, 16'h0008);
      irq_in[3] = 1'b1;
      wr(3'd0, 16'h0008);
      irq_in[3] = 1'b0;
      tick();
      rd("w1c_edge_pend", 3'd0, 16'h0008);
      rd("w1c_edge_missed", 3'd4, 16'h0000);

      // Mask / priority behaviour with sources 1 and 3 pending.
      pulse(1);
      rd("pend_1_3", 3'd0, 16'h000A);
      wr(3'd1, 16'h0008);
      rd("active_m8", 3'd2, 16'h8003);
      wr(3'd1, 16'h000A);
      check("same_cycle_read", readdata, 16'h0008);
      rd("mask_a", 3'd1, 16'h000A);
      rd("active_ma", 3'd2, 16'h8001);
      wr(3'd1, 16'h0000);
      rd("active_m0", 3'd2, 16'h0000);
      check("irq_m0", {15'b0, irq}, 16'h0000);
      wr(3'd3, 16'h0009);
      rd("ack9_pend", 3'd0, 16'h000A);
      rd("ack9_missed", 3'd4, 16'h0000);
      rd("ack9_sel", 3'd5, 16'h0003);

      // RAW register shows registered inputs.
      irq_in = 4'h5;
      tick();
      rd("raw", 3'd6, 16'h0005);

      // Mid-operation reset clears everything.
      reset  = 1'b1;
      irq_in = '0;
      tick();
      reset = 1'b0;
      rd("rst_pend", 3'd0, 16'h0000);
      rd("rst_sel", 3'd5, 16'h0000);
      rd("rst_raw", 3'd6, 16'h0000);
      check("rst_irq", {15'b0, irq}, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
